// File: rtl/add_pipe.sv
// add_pipe: pipelined two-operand unsigned adder with valid/ready on both sides.
//
// Operands are summed as they enter stage 0. Stages 1..STAGES-1 only delay
// {result, sat}. Every stage is elastic: it loads when empty or when its
// current contents move on in the same cycle. Because of that, bubbles
// collapse and a full pipeline still moves one transfer per cycle.
//
// Optional feature (macro ADD_PIPE_ACC_EN): a saturating WIDTH+1-bit
// accumulator. It is updated at input acceptance, so chained accumulates stay
// correct under any back-pressure. Without the macro, in_acc is ignored and
// out_sat is always 0.
//
// Parameters:
//   WIDTH   operand width in bits (>= 1)
//   STAGES  register stages from acceptance to output (1..4)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a/b/in_acc are valid
//   in_ready   block accepts operands this cycle
//   a, b       unsigned operands
//   in_acc     accumulate request (accumulate build only)
//   out_valid  sum/out_sat hold a valid result
//   out_ready  downstream accepts the result this cycle
//   sum        WIDTH+1-bit unsigned result
//   out_sat    result was clamped (accumulate build only)

module add_pipe #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             out_sat
);

    localparam int unsigned RW   = WIDTH + 1;
    localparam int unsigned Last = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] sat_q;
    logic [STAGES-1:0] sat_d;
    logic [RW-1:0]     data_q [STAGES];
    logic [RW-1:0]     data_d [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] adv;
    logic              in_xfer;

    logic [RW-1:0]     result;
    logic              result_sat;
    logic [RW-1:0]     plain_sum;

    assign plain_sum = {1'b0, a} + {1'b0, b};

`ifdef ADD_PIPE_ACC_EN
    logic [RW-1:0] acc_q;
    logic [RW-1:0] acc_d;
    logic [RW:0]   acc_sum;

    // One extra bit holds the true a+b+acc; bit RW set means it exceeds the
    // result range and must clamp to all ones.
    always_comb begin
        acc_sum    = {2'b00, a} + {2'b00, b} + {1'b0, acc_q};
        result     = plain_sum;
        result_sat = 1'b0;
        if (in_acc) begin
            if (acc_sum[RW]) begin
                result     = '1;
                result_sat = 1'b1;
            end else begin
                result = acc_sum[RW-1:0];
            end
        end
        acc_d = in_xfer ? result : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_in_acc;

    assign unused_in_acc = in_acc;

    always_comb begin
        result     = plain_sum;
        result_sat = 1'b0;
    end
`endif

    // Advance/load chain, resolved from the output back towards the input.
    always_comb begin
        load = '0;
        adv  = '0;

        adv[Last]  = v_q[Last] && out_ready;
        load[Last] = !v_q[Last] || adv[Last];
        for (int k = int'(Last) - 1; k >= 0; k--) begin
            adv[k]  = v_q[k] && load[k+1];
            load[k] = !v_q[k] || adv[k];
        end

        in_ready = !rst && load[0];
        in_xfer  = in_valid && in_ready;
    end

    // Data registers change only when a valid item lands in them, so the
    // output holds the last result after the pipeline drains.
    always_comb begin
        v_d    = v_q;
        sat_d  = sat_q;
        data_d = data_q;

        if (load[0]) begin
            v_d[0] = in_xfer;
            if (in_xfer) begin
                data_d[0] = result;
                sat_d[0]  = result_sat;
            end
        end

        for (int k = 1; k < int'(STAGES); k++) begin
            if (load[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    sat_d[k]  = sat_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            sat_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            sat_q <= sat_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = v_q[Last];
    assign sum       = data_q[Last];
    assign out_sat   = sat_q[Last];

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=4, STAGES=2). A queue-based model
// predicts results, timing and in_ready every cycle. Directed scenarios pin
// literal values, and a randomized phase follows them.

module tb_add_pipe;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STAGES = 2;
    localparam int          MAXV   = (1 << (WIDTH + 1)) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             out_sat;

    add_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .in_acc   (in_acc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: in-flight items in FIFO order with their accept edge.
    typedef struct {
        int r;
        bit s;
        int e;
    } item_t;

    item_t q[$];
    int    edge_cnt = 0;
    bit    started  = 1'b0;
    int    macc     = 0;
    int    last_sum = 0;
    bit    last_sat = 1'b0;

    always @(posedge clk) begin
        item_t it;
        int    t;
        edge_cnt++;
        if (rst) begin
            q.delete();
            macc     = 0;
            last_sum = 0;
            last_sat = 1'b0;
            started  = 1'b1;
        end else if (started) begin
            if (out_valid && out_ready && q.size() > 0) begin
                it       = q.pop_front();
                last_sum = it.r;
                last_sat = it.s;
            end
            if (in_valid && in_ready) begin
                it.s = 1'b0;
`ifdef ADD_PIPE_ACC_EN
                if (in_acc) begin
                    t = int'(a) + int'(b) + macc;
                    if (t > MAXV) begin
                        t    = MAXV;
                        it.s = 1'b1;
                    end
                end else begin
                    t = int'(a) + int'(b);
                end
                macc = t;
`else
                t = int'(a) + int'(b);
`endif
                it.r = t;
                it.e = edge_cnt;
                q.push_back(it);
            end
        end
    end

    // The head of the queue has nothing ahead of it, so it reaches the output
    // exactly STAGES-1 edges after acceptance. Any free slot or an output
    // transfer lets stage 0 take new operands.
    always @(negedge clk) begin
        bit exp_valid;
        if (started) begin
            if (rst) begin
                check("in_ready_in_reset", in_ready, 0);
            end else begin
                exp_valid = (q.size() > 0) && (edge_cnt - q[0].e >= int'(STAGES) - 1);
                check("model_out_valid", out_valid, exp_valid);
                check("model_in_ready", in_ready,
                      (q.size() < int'(STAGES)) || (exp_valid && out_ready));
                if (exp_valid) begin
                    check("model_sum", sum, q[0].r);
                    check("model_sat", out_sat, q[0].s);
                end else begin
                    check("model_sum_hold", sum, last_sum);
                    check("model_sat_hold", out_sat, last_sat);
                end
            end
        end
    end

    // Results delivered downstream, for the directed scenarios.
    int got_sum[$];
    bit got_sat[$];

    always @(negedge clk) begin
        if (started && !rst && out_valid && out_ready) begin
            got_sum.push_back(int'(sum));
            got_sat.push_back(out_sat);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic push(input int pa, input int pb, input bit pacc, output int waited);
        in_valid = 1'b1;
        a        = WIDTH'(pa);
        b        = WIDTH'(pb);
        in_acc   = pacc;
        waited   = 0;
        forever begin
            @(posedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                check("push_timeout", 1, 0);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (STAGES + 3) step();
    endtask

    task automatic clear_got();
        got_sum.delete();
        got_sat.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int w;
        bit acc_ok;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_acc    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_in_ready", in_ready, 1);
        step();

        // 1: single transaction, one-cycle result after acceptance
        out_ready = 1'b1;
        push(1, 5, 1'b0, w);
        check("t1_wait", w, 0);
        check("t1_early_valid", out_valid, 0);
        check("t1_early_sum", sum, 0);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_sum", sum, 6);
        step();
        check("t1_valid_once", out_valid, 0);
        check("t1_sum_hold", sum, 6);

        // 2: largest operands
        clear_got();
        push(15, 15, 1'b0, w);
        drain();
        check("t2_count", got_sum.size(), 1);
        if (got_sum.size() == 1) begin
            check("t2_sum", got_sum[0], 30);
            check("t2_sat", got_sat[0], 0);
        end

        // 3: back-to-back at full throughput
        clear_got();
        for (int i = 1; i <= 4; i++) begin
            push(i, i, 1'b0, w);
            check("t3_in_ready", w, 0);
        end
        drain();
        check("t3_count", got_sum.size(), 4);
        for (int i = 0; i < 4 && i < got_sum.size(); i++) begin
            check("t3_sum", got_sum[i], 2 * (i + 1));
        end

        // 4: back-pressure fills the pipeline, output holds
        clear_got();
        out_ready = 1'b0;
        push(1, 1, 1'b0, w);
        check("t4_first_wait", w, 0);
        push(2, 2, 1'b0, w);
        check("t4_second_wait", w, 0);
        in_valid = 1'b1;
        a        = 4'd3;
        b        = 4'd3;
        repeat (3) begin
            check("t4_full_in_ready", in_ready, 0);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_sum", sum, 2);
            step();
        end
        out_ready = 1'b1;
        @(posedge clk);
        acc_ok = in_ready;
        #1;
        in_valid = 1'b0;
        check("t4_third_accept", acc_ok, 1);
        drain();
        check("t4_count", got_sum.size(), 3);
        for (int i = 0; i < 3 && i < got_sum.size(); i++) begin
            check("t4_sum", got_sum[i], 2 * (i + 1));
        end

        // 5: accumulate chain (or plain sums in the default build)
        clear_got();
        push(10, 10, 1'b0, w);
        push(10, 10, 1'b1, w);
        push(0, 1, 1'b1, w);
        drain();
        check("t5_count", got_sum.size(), 3);
        if (got_sum.size() == 3) begin
            check("t5_sum0", got_sum[0], 20);
            check("t5_sat0", got_sat[0], 0);
`ifdef ADD_PIPE_ACC_EN
            check("t5_sum1", got_sum[1], 31);
            check("t5_sat1", got_sat[1], 1);
            check("t5_sum2", got_sum[2], 31);
            check("t5_sat2", got_sat[2], 1);
`else
            check("t5_sum1", got_sum[1], 20);
            check("t5_sat1", got_sat[1], 0);
            check("t5_sum2", got_sum[2], 1);
            check("t5_sat2", got_sat[2], 0);
`endif
        end

        // 6: reset mid-stream discards in-flight work
        clear_got();
        out_ready = 1'b0;
        push(7, 1, 1'b0, w);
        push(4, 4, 1'b0, w);
        rst = 1'b1;
        step();
        check("t6_valid", out_valid, 0);
        check("t6_sum", sum, 0);
        check("t6_in_ready_rst", in_ready, 0);
        rst = 1'b0;
        step();
        check("t6_in_ready", in_ready, 1);
        check("t6_no_result", out_valid, 0);
        out_ready = 1'b1;
        push(2, 3, 1'b0, w);
        drain();
        check("t6_count", got_sum.size(), 1);
        if (got_sum.size() == 1) begin
            check("t6_sum_fresh", got_sum[0], 5);
        end

        // Randomized traffic with back-pressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = $urandom_range(1);
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            in_acc    = $urandom_range(1);
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        drain();
        check("final_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
